// File: rtl/io_timer.sv
// io_timer: bus-mapped 16-bit timer with prescaler, compare match and interrupt.
// Optional PWM output and DUTY registers are built when IO_TIMER_PWM_EN is defined.
module io_timer #(
    parameter logic [7:0] BASE_ADDR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       write_en,
    input  logic       read_en,
    output logic       interrupt,
    input  logic       interrupt_clr
`ifdef IO_TIMER_PWM_EN
    ,
    output logic       pwm_out
`endif
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CMP_L  = 3'd2;
    localparam logic [2:0] OFF_CMP_H  = 3'd3;
    localparam logic [2:0] OFF_CNT_L  = 3'd4;
    localparam logic [2:0] OFF_CNT_H  = 3'd5;
    localparam logic [2:0] OFF_DUTY_L = 3'd6;
    localparam logic [2:0] OFF_DUTY_H = 3'd7;

    // Low PS bits of the prescaler that must all be ones for a tick.
    function automatic logic [6:0] ps_mask(input logic [2:0] ps);
        case (ps)
            3'd0:    ps_mask = 7'h00;
            3'd1:    ps_mask = 7'h01;
            3'd2:    ps_mask = 7'h03;
            3'd3:    ps_mask = 7'h07;
            3'd4:    ps_mask = 7'h0F;
            3'd5:    ps_mask = 7'h1F;
            3'd6:    ps_mask = 7'h3F;
            default: ps_mask = 7'h7F;
        endcase
    endfunction

    logic        en_r, reload_r, ie_r, match_r;
    logic [2:0]  ps_r;
    logic [15:0] cmp_r, cnt_r;
    logic [7:0]  shadow_r, dout_r;
    logic [6:0]  presc_r;

    logic        en_s, reload_s, ie_s, match_s;
    logic [2:0]  ps_s;
    logic [15:0] cmp_s, cnt_s;
    logic [7:0]  shadow_s, dout_s;
    logic [6:0]  presc_s, mask_s;
    logic [7:0]  off_s;
    logic [2:0]  sel_s;
    logic        hit_s, wr_s, rd_s, tick_s, eq_s, match_set_s, match_clr_s;

`ifdef IO_TIMER_PWM_EN
    logic [15:0] duty_r, duty_s;
    logic        pwm_r, pwm_s;
`endif

    // Address decode, prescaler tick and compare detection.
    always_comb begin
        off_s  = address - BASE_ADDR;
        hit_s  = (off_s[7:3] == 5'd0);
        sel_s  = off_s[2:0];
        wr_s   = write_en & hit_s;
        rd_s   = read_en & hit_s;
        mask_s = ps_mask(ps_r);
        tick_s = en_r & ((presc_r & mask_s) == mask_s);
        eq_s   = (cnt_r == cmp_r);
    end

    // Next-state logic; CPU writes are applied last so they override counting.
    always_comb begin
        en_s        = en_r;
        reload_s    = reload_r;
        ie_s        = ie_r;
        ps_s        = ps_r;
        cmp_s       = cmp_r;
        cnt_s       = cnt_r;
        presc_s     = presc_r;
        match_set_s = 1'b0;
        match_clr_s = interrupt_clr;
`ifdef IO_TIMER_PWM_EN
        duty_s      = duty_r;
        pwm_s       = en_r & (cnt_r < duty_r);
`endif

        if (tick_s) begin
            presc_s = 7'd0;
            if (eq_s) begin
                match_set_s = 1'b1;
                if (reload_r) begin
                    cnt_s = 16'd0;
                end else begin
                    en_s = 1'b0;
                end
            end else begin
                cnt_s = cnt_r + 16'd1;
            end
        end else if (en_r) begin
            presc_s = presc_r + 7'd1;
        end else begin
            presc_s = presc_r;
        end

        if (wr_s) begin
            case (sel_s)
                OFF_CTRL: begin
                    en_s     = din[0];
                    reload_s = din[1];
                    ie_s     = din[2];
                    ps_s     = din[5:3];
                    presc_s  = 7'd0;
                end
                OFF_STATUS: match_clr_s = interrupt_clr | din[0];
                OFF_CMP_L:  cmp_s = {cmp_r[15:8], din};
                OFF_CMP_H:  cmp_s = {din, cmp_r[7:0]};
                OFF_CNT_L:  cnt_s = {cnt_r[15:8], din};
                OFF_CNT_H:  cnt_s = {din, cnt_r[7:0]};
`ifdef IO_TIMER_PWM_EN
                OFF_DUTY_L: duty_s = {duty_r[15:8], din};
                OFF_DUTY_H: duty_s = {din, duty_r[7:0]};
`endif
                default: match_clr_s = interrupt_clr;
            endcase
        end else begin
            match_clr_s = interrupt_clr;
        end

        if (match_set_s) begin
            match_s = 1'b1;
        end else if (match_clr_s) begin
            match_s = 1'b0;
        end else begin
            match_s = match_r;
        end
    end

    // Read mux; reading CNT_L latches CNT_H for an atomic 16-bit read.
    always_comb begin
        dout_s   = dout_r;
        shadow_s = shadow_r;
        if (rd_s) begin
            case (sel_s)
                OFF_CTRL:   dout_s = {2'b00, ps_r, ie_r, reload_r, en_r};
                OFF_STATUS: dout_s = {6'b000000, en_r, match_r};
                OFF_CMP_L:  dout_s = cmp_r[7:0];
                OFF_CMP_H:  dout_s = cmp_r[15:8];
                OFF_CNT_L: begin
                    dout_s   = cnt_r[7:0];
                    shadow_s = cnt_r[15:8];
                end
                OFF_CNT_H:  dout_s = shadow_r;
`ifdef IO_TIMER_PWM_EN
                OFF_DUTY_L: dout_s = duty_r[7:0];
                OFF_DUTY_H: dout_s = duty_r[15:8];
`endif
                default:    dout_s = 8'h00;
            endcase
        end else begin
            dout_s = dout_r;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en_r     <= 1'b0;
            reload_r <= 1'b0;
            ie_r     <= 1'b0;
            ps_r     <= 3'd0;
            match_r  <= 1'b0;
            cmp_r    <= 16'd0;
            cnt_r    <= 16'd0;
            shadow_r <= 8'h00;
            presc_r  <= 7'd0;
            dout_r   <= 8'h00;
`ifdef IO_TIMER_PWM_EN
            duty_r   <= 16'd0;
            pwm_r    <= 1'b0;
`endif
        end else begin
            en_r     <= en_s;
            reload_r <= reload_s;
            ie_r     <= ie_s;
            ps_r     <= ps_s;
            match_r  <= match_s;
            cmp_r    <= cmp_s;
            cnt_r    <= cnt_s;
            shadow_r <= shadow_s;
            presc_r  <= presc_s;
            dout_r   <= dout_s;
`ifdef IO_TIMER_PWM_EN
            duty_r   <= duty_s;
            pwm_r    <= pwm_s;
`endif
        end
    end

    assign dout      = dout_r;
    assign interrupt = match_r & ie_r;
`ifdef IO_TIMER_PWM_EN
    assign pwm_out   = pwm_r;
`endif

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h20: I/O low-byte address of register offset 0; block occupies BASE_ADDR..BASE_ADDR+7.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port address  input  8  I/O address low byte from CPU bus.
REQ-005 SHALL have port din  input  8  write data from CPU.
REQ-006 SHALL have port dout  output  8  registered read data.
REQ-007 SHALL have port write_en  input  1  CPU write strobe, one cycle per access.
REQ-008 SHALL have port read_en  input  1  CPU read strobe, one cycle per access.
REQ-009 SHALL have port interrupt  output  1  level interrupt request to CPU.
REQ-010 SHALL have port interrupt_clr  input  1  CPU acknowledge; clears pending match flag.

Function
REQ-011 SHALL map offsets: 0 CTRL, 1 STATUS, 2 CMP_L, 3 CMP_H, 4 CNT_L, 5 CNT_H, 6 DUTY_L, 7 DUTY_H.
REQ-012 CTRL SHALL be bit0 EN, bit1 RELOAD, bit2 IE, bits5:3 PS (prescale 2^PS, 1..128); bits7:6 read 0.
REQ-013 STATUS SHALL be bit0 MATCH (write 1 clears, write 0 no effect), bit1 EN mirror (read-only); others read 0.
REQ-014 Accesses SHALL be decoded only when address is within BASE_ADDR..BASE_ADDR+7; other addresses ignored, dout held.
REQ-015 Read: dout SHALL load selected register on the edge where read_en is high; data valid the following cycle (latency 1).
REQ-016 Reading CNT_L SHALL snapshot CNT_H into a shadow; next CNT_H read returns shadow (atomic 16-bit read); reading CNT_H without prior CNT_L returns shadow value.
REQ-017 Prescaler: 7-bit counter increments each cycle while EN=1; tick SHALL fire when prescaler[PS-1:0] all ones (PS=0: every cycle), prescaler then wraps to 0.
REQ-018 On tick: if CNT==CMP, SHALL set MATCH and either reset CNT to 0 (RELOAD=1) or hold CNT and clear EN (one-shot, RELOAD=0); else CNT+1, 16-bit wrap 16'hFFFF->0 without flag.
REQ-019 EN written 0 or any CTRL write SHALL clear prescaler to 0.
REQ-020 CPU write to CNT_L/CNT_H SHALL take precedence over same-cycle increment or reload.
REQ-021 interrupt SHALL equal MATCH & IE, combinational from registered state.
REQ-022 interrupt_clr or STATUS write-1 SHALL clear MATCH; a same-cycle match set SHALL win over clear.
REQ-023 write_en and read_en both high SHALL perform the write and the read; read returns pre-write value.
REQ-024 CMP==0 with RELOAD=1 SHALL set MATCH on every tick.

Reset
REQ-025 On reset low at a clock edge: CTRL, STATUS, CMP, CNT, shadow, prescaler, DUTY, dout SHALL be 0; interrupt SHALL be 0 the next cycle.
REQ-026 Reset mid-count SHALL abort counting; no MATCH generated in the reset cycle; bus accesses during reset ignored.

Configuration
REQ-027 Macro IO_TIMER_PWM_EN defined: SHALL add port pwm_out output 1, registered, high when EN=1 and CNT<DUTY, low otherwise; DUTY_L/H read/write.
REQ-028 Macro IO_TIMER_PWM_EN undefined: pwm_out port and DUTY registers SHALL be absent; offsets 6/7 read 0, writes ignored.

Verification
REQ-029 Write CMP=16'h0003, CTRL=8'h07 (EN,RELOAD,IE,PS=0) -> MATCH and interrupt high 4 ticks after enable, CNT reads 0 after reload, repeats every 4 cycles.
REQ-030 CMP=16'h0002, CTRL=8'h05 (one-shot) -> MATCH set once, EN reads 0 in STATUS, CNT holds 2.
REQ-031 PS=3, CMP=1 -> CNT increments every 8 cycles; MATCH after 16 cycles.
REQ-032 Pulse interrupt_clr on the same cycle a new match occurs -> MATCH stays 1; clr alone later -> interrupt low next cycle.
REQ-033 CNT=16'h12FF running, read CNT_L then (after rollover) CNT_H -> returns 8'hFF then 8'h12.
REQ-034 With IO_TIMER_PWM_EN: DUTY=2, CMP=3, RELOAD, PS=0 -> pwm_out pattern 1,1,0,0 repeating; unmapped address 8'h30 read leaves dout unchanged.
